// File: rtl/mul_cell_pkg.sv
// mul_cell_pkg: shared op encodings, FSM state type and widths for the multiplier-cell back end.
// Optional feature macro: MUL_CELL_MULX_EN (enables the MULX high-word ops).
package mul_cell_pkg;
    localparam int DATA_W = 32;
    localparam int HALF_W = DATA_W / 2;
    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULXUU = 2'd1;
    localparam logic [1:0] MUL_OP_MULXSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULXSS = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE1,
        S_CAP1,
        S_CAP2,
        S_SUM,
        S_DONE
    } state_t;
endpackage

// File: rtl/mul_cell_combine_if.sv
// mul_cell_combine_if: request bus from the execute stage plus the multiplier-cell bus.
// Ports: start/op/src1/src2/flush -> busy/done/result (request side);
//        cell_src1/cell_src2/cell_en -> cell_p1/cell_p2/cell_p3 (cell side).
// slave = the combine block, master = execute stage together with the cell.
interface mul_cell_combine_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;
    modport master (
        output start, op, src1, src2, flush, cell_p1, cell_p2, cell_p3,
        input  busy, done, result, cell_src1, cell_src2, cell_en
    );
    modport slave (
        input  start, op, src1, src2, flush, cell_p1, cell_p2, cell_p3,
        output busy, done, result, cell_src1, cell_src2, cell_en
    );
endinterface

// File: rtl/mul_cell_sum.sv
// mul_cell_sum: combinational partial-product adder with signed high-word correction.
// Ports: i_ll/i_lh/i_hl/i_hh partial products, i_a/i_b operands, i_op op code -> o_result word.
module mul_cell_sum
    import mul_cell_pkg::*;
(
    input  logic [DATA_W-1:0] i_ll,
    input  logic [DATA_W-1:0] i_lh,
    input  logic [DATA_W-1:0] i_hl,
    input  logic [DATA_W-1:0] i_hh,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [1:0]        i_op,
    output logic [DATA_W-1:0] o_result
);
    logic [DATA_W:0]     w_mid;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_corr;
    always_comb begin
        w_mid    = {1'b0, i_lh} + {1'b0, i_hl};
        w_prod   = {{DATA_W{1'b0}}, i_ll} + ({{(DATA_W-1){1'b0}}, w_mid} << HALF_W) + {i_hh, {DATA_W{1'b0}}};
        // Unsigned high word minus the sign-extension terms of each signed operand.
        w_corr   = (((i_op == MUL_OP_MULXSU) || (i_op == MUL_OP_MULXSS)) && i_a[DATA_W-1] ? i_b : '0)
                 + ((i_op == MUL_OP_MULXSS) && i_b[DATA_W-1] ? i_a : '0);
        o_result = (i_op == MUL_OP_MUL) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W] - w_corr;
    end
endmodule

// File: rtl/mul_cell_combine.sv
// mul_cell_combine: sequences the 16x16 multiplier cell and assembles the 32-bit product.
// Ports: clk, reset_n (async active-low), bus (mul_cell_combine_if.slave: request + cell signals).
// Macro MUL_CELL_MULX_EN builds the second cell pass and MULX high-word ops; otherwise every op is MUL.
module mul_cell_combine
    import mul_cell_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    mul_cell_combine_if.slave bus
);
    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_a, r_b, r_ll, r_lh, r_hl, r_result;
    logic [DATA_W-1:0] w_hh, w_sum;
    logic [1:0]        w_op;
    logic              w_mulx, w_issue1, w_issue2;
`ifdef MUL_CELL_MULX_EN
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_hh;
    assign w_op = r_op;
    assign w_hh = r_hh;
`else
    assign w_op = MUL_OP_MUL;
    assign w_hh = '0;
`endif
    assign w_mulx   = w_op != MUL_OP_MUL;
    // A flush cancels any cell issue in the same cycle.
    assign w_issue1 = (r_state == S_ISSUE1) && !bus.flush;
    assign w_issue2 = (r_state == S_CAP1) && w_mulx && !bus.flush;
    assign bus.busy      = r_state != S_IDLE;
    assign bus.done      = r_state == S_DONE;
    assign bus.result    = r_result;
    assign bus.cell_en   = w_issue1 || w_issue2;
    assign bus.cell_src1 = w_issue1 ? r_a : w_issue2 ? {{HALF_W{1'b0}}, r_a[DATA_W-1:HALF_W]} : '0;
    assign bus.cell_src2 = w_issue1 ? r_b : w_issue2 ? {{HALF_W{1'b0}}, r_b[DATA_W-1:HALF_W]} : '0;
    mul_cell_sum u_sum (
        .i_ll     (r_ll),
        .i_lh     (r_lh),
        .i_hl     (r_hl),
        .i_hh     (w_hh),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (w_op),
        .o_result (w_sum)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = bus.start ? S_ISSUE1 : S_IDLE;
            S_ISSUE1: w_next = S_CAP1;
            S_CAP1:   w_next = w_mulx ? S_CAP2 : S_SUM;
            S_CAP2:   w_next = S_SUM;
            S_SUM:    w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && bus.flush) w_next = S_IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_ll     <= '0;
            r_lh     <= '0;
            r_hl     <= '0;
            r_result <= '0;
`ifdef MUL_CELL_MULX_EN
            r_op     <= MUL_OP_MUL;
            r_hh     <= '0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_a  <= bus.src1;
                r_b  <= bus.src2;
`ifdef MUL_CELL_MULX_EN
                r_op <= bus.op;
`endif
            end
            if (r_state == S_CAP1) begin
                r_ll <= bus.cell_p1;
                r_lh <= bus.cell_p2;
                r_hl <= bus.cell_p3;
            end
`ifdef MUL_CELL_MULX_EN
            if (r_state == S_CAP2) r_hh <= bus.cell_p1;
`endif
            if (r_state == S_SUM && !bus.flush) r_result <= w_sum;
        end
    end
endmodule

// File: tb/tb_mul_cell_combine.sv
// tb_mul_cell_combine: directed self-checking bench with a cycle-timeline model and a cell model.
// Expected values follow MUL_CELL_MULX_EN when defined, plain MUL otherwise.
module tb_mul_cell_combine;
    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_age, m_lat;
    logic [31:0] m_exp, m_res, m_a, m_b;
    mul_cell_combine_if bus ();
    mul_cell_combine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );
`ifdef MUL_CELL_MULX_EN
    localparam logic [31:0] E_UU = 32'hFFFF_FFFE, E_SS = 32'h0, E_SU = 32'hFFFF_FFFF, E_OP3 = 32'h2;
    localparam int LX = 5;
    function automatic logic [1:0] eff_op(input logic [1:0] op);
        return op;
    endfunction
`else
    localparam logic [31:0] E_UU = 32'h1, E_SS = 32'h1, E_SU = 32'hFFFF_FFFE, E_OP3 = 32'h000B_000F;
    localparam int LX = 4;
    function automatic logic [1:0] eff_op(input logic [1:0] op);
        return op & 2'b00;
    endfunction
`endif
    // Product from full-width arithmetic: sign-extend signed operands, take the requested word.
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (op >= 2'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (op == 2'd3) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Registered partial-product cell.
    always @(posedge clk) begin
        if (bus.cell_en) begin
            bus.cell_p1 <= {16'b0, bus.cell_src1[15:0]} * {16'b0, bus.cell_src2[15:0]};
            bus.cell_p2 <= {16'b0, bus.cell_src1[15:0]} * {16'b0, bus.cell_src2[31:16]};
            bus.cell_p3 <= {16'b0, bus.cell_src1[31:16]} * {16'b0, bus.cell_src2[15:0]};
        end
    end
    // Timeline model: m_age counts cycles since acceptance; done at m_age == m_lat.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_age <= 0;
            m_lat <= 4;
            m_res <= '0;
            m_exp <= '0;
            m_a   <= '0;
            m_b   <= '0;
        end else if (m_age == 0) begin
            if (bus.start) begin
                m_age <= 1;
                m_lat <= (eff_op(bus.op) == 2'd0) ? 4 : 5;
                m_exp <= model(eff_op(bus.op), bus.src1, bus.src2);
                m_a   <= bus.src1;
                m_b   <= bus.src2;
            end
        end else if (bus.flush || m_age == m_lat) begin
            m_age <= 0;
        end else begin
            m_age <= m_age + 1;
            if (m_age + 1 == m_lat) m_res <= m_exp;
        end
    end
    always @(negedge clk) begin
        if (reset_n) begin
            chk("busy", 32'(bus.busy), 32'(m_age != 0));
            chk("done", 32'(bus.done), 32'(m_age != 0 && m_age == m_lat));
            chk("cell_en", 32'(bus.cell_en), 32'(!bus.flush && (m_age == 1 || (m_age == 2 && m_lat == 5))));
            chk("result", bus.result, m_res);
            if (m_age == 1 && !bus.flush) begin
                chk("cell_src1_p1", bus.cell_src1, m_a);
                chk("cell_src2_p1", bus.cell_src2, m_b);
            end
            if (m_age == 2 && m_lat == 5 && !bus.flush) begin
                chk("cell_src1_p2", bus.cell_src1, {16'h0, m_a[31:16]});
                chk("cell_src2_p2", bus.cell_src2, {16'h0, m_b[31:16]});
            end
        end
    end
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
        end
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_result"}, bus.result, exp_res);
    endtask
    initial begin
        int n, dones;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'd0;
        bus.src1      = '0;
        bus.src2      = '0;
        bus.flush     = 1'b0;
        bus.cell_p1   = '0;
        bus.cell_p2   = '0;
        bus.cell_p3   = '0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cell_en", 32'(bus.cell_en), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_cell_src1", bus.cell_src1, 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        run_op("mul", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 4);
        run_op("mulxuu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_UU, LX);
        run_op("mulxss", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, E_SS, LX);
        run_op("mulxsu", 2'd2, 32'hFFFF_FFFF, 32'h0000_0002, E_SU, LX);
        run_op("op3", 2'd3, 32'h0001_0003, 32'h0002_0005, E_OP3, LX);
        // Flush on the third cycle of a MULXUU.
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.src1  = 32'h1234_5678;
        bus.src2  = 32'h8765_4321;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_done", 32'(bus.done), 32'd0);
        #1;
        bus.flush = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("flush_no_done", 32'(dones), 32'd0);
        chk("flush_result_kept", bus.result, E_OP3);
        run_op("mul_after_flush", 2'd0, 32'h1234_5678, 32'h0000_0009, 32'hA3D7_0A38, 4);
        // Asynchronous reset in the middle of ISSUE1.
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.op    = 2'd0;
        bus.src1  = 32'h0001_0003;
        bus.src2  = 32'h0002_0005;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("issue1_cell_en", 32'(bus.cell_en), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_cell_en", 32'(bus.cell_en), 32'd0);
        chk("arst_result", bus.result, 32'd0);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        // start pulsed while busy must be ignored.
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.src1  = 32'h0000_0007;
        bus.src2  = 32'h0000_0006;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        #1;
        bus.start = 1'b1;
        bus.src1  = 32'h0000_0100;
        bus.src2  = 32'h0000_0100;
        @(negedge clk);
        #1;
        bus.start = 1'b0;
        n = 3;
        while (n < 20 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        chk("busy_start_latency", 32'(n), 32'd4);
        chk("busy_start_result", bus.result, 32'h0000_002A);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("busy_start_no_extra_done", 32'(dones), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
